// File: rtl/frame_aligner_lock.sv
// S-bit frame aligner: decodes one-hot SoT into a per-lane bitslip, with HUNT/VERIFY/LOCKED flywheel.
// Defining FRAME_ALIGNER_ERR_CNT_EN implements the sot_err_cnt_o counter; otherwise it is tied to 0.
module frame_aligner_lock #(
  parameter int unsigned FRAME_SIZE = 8,
  parameter int unsigned MXSBITS    = 64,
  parameter int unsigned SW         = $clog2(FRAME_SIZE),
  parameter int unsigned CNT_W      = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [MXSBITS-1:0]    sbits_i,
  input  logic [FRAME_SIZE-1:0] start_of_frame_i,
  input  logic                  mask_i,
  input  logic [SW-1:0]         slip_offset_i,
  input  logic [CNT_W-1:0]      aligned_count_to_ready_i,
  input  logic [CNT_W-1:0]      bad_count_to_unlock_i,
  output logic [MXSBITS-1:0]    sbits_o,
  output logic [SW-1:0]         bitslip_cnt_o,
  output logic                  sot_is_aligned_o,
  output logic                  sot_unstable_o,
  output logic [15:0]           sot_err_cnt_o
);

  localparam int unsigned NL = MXSBITS / FRAME_SIZE;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] stable_q, stable_d, stable_next;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [CNT_W:0]   bad_inc;
  logic [SW-1:0]    locked_slip_q, locked_slip_d;
  logic [SW-1:0]    bitslip_q, bitslip_d;
  logic             unstable_q, unstable_d;
  logic             aligned_q;

  logic [MXSBITS-1:0]      sbits_cur_q, sbits_prev_q, sbits_out_q, sbits_slip;
  logic [2*FRAME_SIZE-1:0] win;

  logic [FRAME_SIZE-1:0] sof_q;
  logic                  good_d, good_q;
  logic [SW-1:0]         sof_pos, cand_d, cand_q;

  // Window is {current frame, previous frame}; slip k selects bits [k+FRAME_SIZE-1:k].
  always_comb begin
    sbits_slip = '0;
    win        = '0;
    for (int l = 0; l < NL; l++) begin
      win = {sbits_cur_q[l*FRAME_SIZE +: FRAME_SIZE], sbits_prev_q[l*FRAME_SIZE +: FRAME_SIZE]};
      sbits_slip[l*FRAME_SIZE +: FRAME_SIZE] = win[bitslip_q +: FRAME_SIZE];
    end
  end

  always_comb begin
    sof_pos = '0;
    for (int i = 0; i < FRAME_SIZE; i++) begin
      if (sof_q[i]) sof_pos = SW'(i);
    end
    good_d = $onehot(sof_q);
    cand_d = sof_pos + slip_offset_i;
  end

  always_comb begin
    state_d       = state_q;
    stable_d      = stable_q;
    bad_d         = bad_q;
    locked_slip_d = locked_slip_q;
    bitslip_d     = bitslip_q;
    unstable_d    = unstable_q;
    stable_next   = (stable_q == CntMax) ? stable_q : stable_q + 1'b1;
    bad_inc       = {1'b0, bad_q} + 1'b1;

    if (mask_i) begin
      state_d  = StHunt;
      stable_d = '0;
      bad_d    = '0;
    end else begin
      case (state_q)
        StHunt: begin
          if (good_q) begin
            state_d       = StVerify;
            stable_d      = CNT_W'(1);
            locked_slip_d = cand_q;
            bitslip_d     = cand_q;
          end
        end
        StVerify: begin
          if (!good_q) begin
            state_d  = StHunt;
            stable_d = '0;
          end else begin
            if (cand_q == locked_slip_q) begin
              stable_d = stable_next;
            end else begin
              locked_slip_d = cand_q;
              stable_d      = CNT_W'(1);
            end
            bitslip_d = locked_slip_d;
            if (stable_d >= aligned_count_to_ready_i) begin
              state_d = StLocked;
              bad_d   = '0;
            end
          end
        end
        StLocked: begin
          if (good_q && (cand_q == locked_slip_q)) begin
            bad_d = '0;
          end else if (bad_inc > {1'b0, bad_count_to_unlock_i}) begin
            state_d    = StHunt;
            unstable_d = 1'b1;
            bad_d      = '0;
            stable_d   = '0;
          end else begin
            bad_d = (bad_q == CntMax) ? bad_q : bad_inc[CNT_W-1:0];
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sbits_cur_q   <= '0;
      sbits_prev_q  <= '0;
      sbits_out_q   <= '0;
      sof_q         <= '0;
      good_q        <= 1'b0;
      cand_q        <= '0;
      state_q       <= StHunt;
      stable_q      <= '0;
      bad_q         <= '0;
      locked_slip_q <= '0;
      bitslip_q     <= '0;
      unstable_q    <= 1'b0;
      aligned_q     <= 1'b0;
    end else begin
      sbits_cur_q   <= sbits_i;
      sbits_prev_q  <= sbits_cur_q;
      sbits_out_q   <= mask_i ? '0 : sbits_slip;
      sof_q         <= start_of_frame_i;
      good_q        <= good_d;
      cand_q        <= cand_d;
      state_q       <= state_d;
      stable_q      <= stable_d;
      bad_q         <= bad_d;
      locked_slip_q <= locked_slip_d;
      bitslip_q     <= bitslip_d;
      unstable_q    <= unstable_d;
      aligned_q     <= (state_q == StLocked);
    end
  end

`ifdef FRAME_ALIGNER_ERR_CNT_EN
  logic        err_inc;
  logic [15:0] err_cnt_q;

  // Any frame in LOCKED that is not the locked one-hot position counts as an error.
  assign err_inc = !mask_i && (state_q == StLocked) && !(good_q && (cand_q == locked_slip_q));

  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign sot_err_cnt_o = err_cnt_q;
`else
  assign sot_err_cnt_o = '0;
`endif

  assign sbits_o          = sbits_out_q;
  assign bitslip_cnt_o    = bitslip_q;
  assign sot_is_aligned_o = aligned_q;
  assign sot_unstable_o   = unstable_q;

endmodule
